// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 32-bit ALU: queues opcode/operand commands, issues them one at a
// time on registered outputs and returns each captured ALU result. Optional: RESULT_ZERO_FLAG_EN.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [5:0]               cmdOpcode,
    input  logic [WIDTH-1:0]         cmdFirst,
    input  logic [WIDTH-1:0]         cmdSecond,
    output logic [WIDTH-1:0]         aluFirst,
    output logic [WIDTH-1:0]         aluSecond,
    output logic [5:0]               aluOpcode,
    input  logic [WIDTH-1:0]         aluResult,
    output logic                     resultValid,
    input  logic                     resultReady,
    output logic [WIDTH-1:0]         resultData,
    output logic [$clog2(DEPTH):0]   pendingCount,
`ifdef RESULT_ZERO_FLAG_EN
    output logic                     resultZero,
`endif
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_e;

    typedef struct packed {
        logic [5:0]       opcode;
        logic [WIDTH-1:0] first;
        logic [WIDTH-1:0] second;
    } cmd_t;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   alu_first_q, alu_first_d;
    logic [WIDTH-1:0]   alu_second_q, alu_second_d;
    logic [5:0]         alu_opcode_q, alu_opcode_d;
    logic               result_valid_q, result_valid_d;
    logic [WIDTH-1:0]   result_data_q, result_data_d;
    logic               zero_q, zero_d;

    cmd_t               mem_q [DEPTH];
    cmd_t               cmd_in;
    cmd_t               head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign cmd_in = '{opcode: cmdOpcode, first: cmdFirst, second: cmdSecond};
    assign head   = mem_q[rd_ptr_q];
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    // cmdReady looks only at registered occupancy, never at this cycle's pop.
    assign push   = cmdValid && !full;

    // NOTE: the queue storage has no reset; stale entries are never read because
    // the occupancy counter, which is reset, gates every pop.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred,
    // and uses blocking assignments; the registers below use non-blocking only.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        alu_first_d    = alu_first_q;
        alu_second_d   = alu_second_q;
        alu_opcode_d   = alu_opcode_q;
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        zero_d         = zero_q;
        pop            = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                result_data_d  = aluResult;
                zero_d         = (aluResult == '0);
                result_valid_d = 1'b1;
                state_d        = HOLD;
            end
            HOLD: begin
                if (resultReady) begin
                    result_valid_d = 1'b0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            alu_first_d  = head.first;
            alu_second_d = head.second;
            alu_opcode_d = head.opcode;
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            alu_first_q    <= '0;
            alu_second_q   <= '0;
            alu_opcode_q   <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            zero_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            alu_first_q    <= alu_first_d;
            alu_second_q   <= alu_second_d;
            alu_opcode_q   <= alu_opcode_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            zero_q         <= zero_d;
        end
    end

    assign cmdReady     = !full;
    assign aluFirst     = alu_first_q;
    assign aluSecond    = alu_second_q;
    assign aluOpcode    = alu_opcode_q;
    assign resultValid  = result_valid_q;
    assign resultData   = result_data_q;
    assign pendingCount = count_q;
    assign busy         = (state_q != IDLE) || !empty;

`ifdef RESULT_ZERO_FLAG_EN
    assign resultZero = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed latency/backpressure/reset steps plus a
// randomized phase scored against a command queue and a behavioural ALU model.
module tb_alu_op_sequencer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   resetN;
    logic                   cmdValid;
    logic                   cmdReady;
    logic [5:0]             cmdOpcode;
    logic [WIDTH-1:0]       cmdFirst;
    logic [WIDTH-1:0]       cmdSecond;
    logic [WIDTH-1:0]       aluFirst;
    logic [WIDTH-1:0]       aluSecond;
    logic [5:0]             aluOpcode;
    logic [WIDTH-1:0]       aluResult;
    logic                   resultValid;
    logic                   resultReady;
    logic [WIDTH-1:0]       resultData;
    logic [$clog2(DEPTH):0] pendingCount;
    logic                   busy;
`ifdef RESULT_ZERO_FLAG_EN
    logic                   resultZero;
`endif

    int n_pass    = 0;
    int n_total   = 0;
    int n_results = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] held_data;

    alu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .cmdValid     (cmdValid),
        .cmdReady     (cmdReady),
        .cmdOpcode    (cmdOpcode),
        .cmdFirst     (cmdFirst),
        .cmdSecond    (cmdSecond),
        .aluFirst     (aluFirst),
        .aluSecond    (aluSecond),
        .aluOpcode    (aluOpcode),
        .aluResult    (aluResult),
        .resultValid  (resultValid),
        .resultReady  (resultReady),
        .resultData   (resultData),
        .pendingCount (pendingCount),
`ifdef RESULT_ZERO_FLAG_EN
        .resultZero   (resultZero),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the ALU sitting behind the sequencer.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [5:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op[5:4])
            2'b00: return op[3] ? a - b : a + b;
            2'b01: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
            2'b10: begin
                case (op[1:0])
                    2'b00:   return a & b;
                    2'b01:   return a | b;
                    2'b10:   return a ^ b;
                    default: return ~a;
                endcase
            end
            default: return op[0] ? (a >> b[4:0]) : (a << b[4:0]);
        endcase
    endfunction

    always_comb aluResult = alu_fn(aluOpcode, aluFirst, aluSecond);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [5:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        cmdOpcode = op;
        cmdFirst  = a;
        cmdSecond = b;
        cmdValid  = 1'b1;
    endtask

    // One clock: score the handshakes visible before the edge, then advance to edge+1.
    task automatic step();
        logic acc;
        logic hs;
        logic [WIDTH-1:0] e;
        acc = cmdValid && cmdReady;
        hs  = resultValid && resultReady;
        if (!resultValid) check("data_held", resultData, held_data);
        if (hs) begin
            check("result_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("result_data", resultData, e);
`ifdef RESULT_ZERO_FLAG_EN
                check("result_zero", resultZero, (e == '0));
`endif
                held_data = e;
                n_results++;
            end
        end
        if (acc) exp_q.push_back(alu_fn(cmdOpcode, cmdFirst, cmdSecond));
        @(posedge clk);
        #1;
        if (acc) cmdValid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || cmdValid); i++) step();
        check("drain_done", exp_q.size(), 0);
        check("drain_cmd_taken", cmdValid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        resetN      = 1'b0;
        cmdValid    = 1'b0;
        cmdOpcode   = '0;
        cmdFirst    = '0;
        cmdSecond   = '0;
        resultReady = 1'b0;
        held_data   = '0;

        // Reset state
        #12;
        check("rst_cmdReady", cmdReady, 1);
        check("rst_resultValid", resultValid, 0);
        check("rst_resultData", resultData, 0);
        check("rst_aluFirst", aluFirst, 0);
        check("rst_pending", pendingCount, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Single add: latency E0 accept, E1 load, E2 result
        resultReady = 1'b1;
        drive(6'b000000, 32'd5, 32'd7);
        step();
        check("add_pending_E0", pendingCount, 1);
        check("add_busy_E0", busy, 1);
        step();
        check("add_aluFirst_E1", aluFirst, 5);
        check("add_aluSecond_E1", aluSecond, 7);
        check("add_aluOpcode_E1", aluOpcode, 0);
        check("add_rv_E1", resultValid, 0);
        step();
        check("add_rv_E2", resultValid, 1);
        check("add_data_E2", resultData, 12);
        step();
        check("add_rv_after_hs", resultValid, 0);
        check("add_busy_after_hs", busy, 0);

        // Back-to-back subtracts, results 2 cycles apart
        drive(6'b001000, 32'd10, 32'd3);
        step();
        drive(6'b001000, 32'd3, 32'd10);
        step();
        step();
        check("sub1_rv", resultValid, 1);
        check("sub1_data", resultData, 7);
        step();
        check("sub_gap_rv", resultValid, 0);
        step();
        check("sub2_rv", resultValid, 1);
        check("sub2_data", resultData, 32'hFFFF_FFF9);
        step();
        check("sub_busy_end", busy, 0);

        // Backpressure: 5 commands fill issue slot + FIFO, 6th stalls
        resultReady = 1'b0;
        base = n_results;
        for (int k = 0; k < 5; k++) begin
            drive(6'b000000, WIDTH'(100 + k), WIDTH'(k));
            step();
            check("bp_accept", cmdValid, 0);
        end
        check("bp_pending_full", pendingCount, 4);
        check("bp_cmdReady_low", cmdReady, 0);
        check("bp_issued_first", aluFirst, 100);
        check("bp_rv", resultValid, 1);
        drive(6'b001000, 32'd105, 32'd5);
        repeat (3) step();
        check("bp_sixth_stalled", cmdValid, 1);
        check("bp_pending_still_full", pendingCount, 4);
        resultReady = 1'b1;
        drain(60);
        check("bp_result_count", n_results - base, 6);

        // Simultaneous push and pop in HOLD with two queued
        resultReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(6'b000000, WIDTH'(200 + k), 32'd1);
            step();
        end
        check("pp_pending_before", pendingCount, 2);
        check("pp_rv_before", resultValid, 1);
        resultReady = 1'b1;
        drive(6'b000000, 32'd203, 32'd1);
        step();
        check("pp_pending_after", pendingCount, 2);
        check("pp_oldest_issued", aluFirst, 201);
        drain(40);

        // Reset during ISSUE
        resultReady = 1'b0;
        drive(6'b000000, 32'd300, 32'd1);
        step();
        drive(6'b000000, 32'd301, 32'd1);
        step();
        drive(6'b000000, 32'd302, 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        check("mr_aluFirst", aluFirst, 0);
        check("mr_aluSecond", aluSecond, 0);
        check("mr_aluOpcode", aluOpcode, 0);
        check("mr_rv", resultValid, 0);
        check("mr_data", resultData, 0);
        check("mr_pending", pendingCount, 0);
        check("mr_busy", busy, 0);
        check("mr_cmdReady", cmdReady, 1);
        cmdValid = 1'b0;
        exp_q.delete();
        held_data = '0;
        resultReady = 1'b1;
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        repeat (6) begin
            check("mr_no_result", resultValid, 0);
            step();
        end
        check("mr_idle_busy", busy, 0);

`ifdef RESULT_ZERO_FLAG_EN
        // Zero flag
        drive(6'b001000, 32'd9, 32'd9);
        repeat (3) step();
        check("zf_data", resultData, 0);
        check("zf_zero_set", resultZero, 1);
        step();
        drive(6'b000000, 32'd1, 32'd1);
        repeat (3) step();
        check("zf_data2", resultData, 2);
        check("zf_zero_clear", resultZero, 0);
        step();
`endif

        // Randomized traffic with random backpressure
        base = n_results;
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 400; c++) begin
                if (!cmdValid && sent < 80 && ($urandom % 3) != 0) begin
                    drive(6'($urandom), $urandom, $urandom);
                    sent++;
                end
                resultReady = (($urandom % 4) != 0);
                step();
            end
            resultReady = 1'b1;
            drain(400);
            check("rand_result_count", n_results - base, sent);
        end
        check("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
